jtcontra_paldma: RTL and testbench

Palette upload engine: the write-side master of the palette RAM port consumed by the colour mixer. On a start pulse it fetches a block of bytes from a byte-wide source memory (ROM/SDRAM slot with req/ok handshake) and replays them as single-cycle CPU-style palette writes (`pal_cs`, `cpu_rnw`, `cpu_cen`, address, data). It sits between the game-data fetch logic and the palette RAM write port, muxed with the real CPU by the top level while `busy` is high.

---
 rtl/jtcontra_paldma.sv | 141 ++++++++++++++
 tb/tb_jtcontra_paldma.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_paldma.sv
// Palette upload engine: copies LEN source bytes into palette RAM at BASE+n.
// Ports: clk/rst, LVBL, start/abort, busy/done, src_* fetch, pal_*/cpu_* write.
// JTCONTRA_PALDMA_VBLANK_EN: when defined, fetches start only while LVBL=0.
module jtcontra_paldma #(
  parameter int         LEN  = 256,
  parameter logic [7:0] BASE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LVBL,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       src_cs,
  output logic [7:0] src_addr,
  input  logic [7:0] src_data,
  input  logic       src_ok,
  output logic       pal_cs,
  output logic       cpu_rnw,
  output logic       cpu_cen,
  output logic [7:0] pal_addr,
  output logic [7:0] pal_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  // 9 bits so LEN=256 gives a last index of 255
  localparam logic [8:0] LAST = 9'(LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] din_q, din_d;
  logic [7:0] paddr_q, paddr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_q, cs_d;
  logic       wr_q, wr_d;
  logic       rnw_q, rnw_d;
  logic       wait_ok;
  logic       last;

`ifdef JTCONTRA_PALDMA_VBLANK_EN
  assign wait_ok = ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
  assign wait_ok     = 1'b1;
`endif

  assign last = {1'b0, cnt_q} == LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    paddr_d = paddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        if (abort)        state_d = S_IDLE;
        else if (wait_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (src_ok) begin
          din_d   = src_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // the write on the bus this cycle completes regardless of abort
        if (abort) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from the next state
    busy_d = (state_d == S_WAIT) || (state_d == S_FETCH) ||
             (state_d == S_WRITE);
    done_d = state_d == S_DONE;
    cs_d   = state_d == S_FETCH;
    wr_d   = state_d == S_WRITE;
    rnw_d  = ~wr_d;
    if (wr_d) paddr_d = BASE + cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      din_q   <= 8'd0;
      paddr_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rnw_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      paddr_q <= paddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rnw_q   <= rnw_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign src_cs   = cs_q;
  assign src_addr = cnt_q;
  assign pal_cs   = wr_q;
  assign cpu_cen  = wr_q;
  assign cpu_rnw  = rnw_q;
  assign pal_addr = paddr_q;
  assign pal_din  = din_q;

endmodule

// File: tb/tb_jtcontra_paldma.sv
// Bench for jtcontra_paldma: two instances (LEN=256/BASE=00, LEN=4/BASE=FE)
// fed by latency-programmable source models and checked per write.
module tb_jtcontra_paldma;

  localparam int         LA = 256;
  localparam int         LB = 4;
  localparam logic [7:0] BA = 8'h00;
  localparam logic [7:0] BB = 8'hFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic LVBL;
  logic [1:0] start = '0;
  logic [1:0] abort = '0;
  logic [1:0] busy, done, src_cs, src_ok;
  logic [1:0] pal_cs, cpu_rnw, cpu_cen;
  logic [1:0][7:0] src_addr, src_data, pal_addr, pal_din;

  jtcontra_paldma #(.LEN(LA), .BASE(BA)) u_a (
    .clk(clk), .rst(rst), .LVBL(LVBL),
    .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]),
    .src_cs(src_cs[0]), .src_addr(src_addr[0]),
    .src_data(src_data[0]), .src_ok(src_ok[0]),
    .pal_cs(pal_cs[0]), .cpu_rnw(cpu_rnw[0]),
    .cpu_cen(cpu_cen[0]), .pal_addr(pal_addr[0]),
    .pal_din(pal_din[0])
  );

  jtcontra_paldma #(.LEN(LB), .BASE(BB)) u_b (
    .clk(clk), .rst(rst), .LVBL(LVBL),
    .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]),
    .src_cs(src_cs[1]), .src_addr(src_addr[1]),
    .src_data(src_data[1]), .src_ok(src_ok[1]),
    .pal_cs(pal_cs[1]), .cpu_rnw(cpu_rnw[1]),
    .cpu_cen(cpu_cen[1]), .pal_addr(pal_addr[1]),
    .pal_din(pal_din[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0] mem[2][256];
  int lat[2][256];
  int wcnt[2];
  int wr_cnt[2];
  int done_cnt[2];
  int done_rel[2];
  int t0[2];
  logic prev_cen[2];

  typedef struct {
    int d;         // which instance
    int lat;       // source latency, -1 = random 0..3
    int abort_at;  // byte whose FETCH gets aborted, -1 = none
    int rnd_data;  // 0: data = ~addr, 1: random
    int exp_wr;    // writes expected
    int exp_done;  // done cycle, -1 = from model, 0 = none
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] base_of(input int d);
    return (d == 0) ? BA : BB;
  endfunction

  // monitor and source responder, both on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cpu_cen[d]) begin
        chk("cen_gap", 32'(prev_cen[d]), 0);
        chk("wr_pal_cs", 32'(pal_cs[d]), 1);
        chk("wr_rnw", 32'(cpu_rnw[d]), 0);
        chk("wr_busy", 32'(busy[d]), 1);
        chk("wr_addr", 32'(pal_addr[d]),
            32'(8'(base_of(d) + 8'(wr_cnt[d]))));
        chk("wr_data", 32'(pal_din[d]), 32'(mem[d][wr_cnt[d] % 256]));
        wr_cnt[d]++;
      end
      prev_cen[d] = cpu_cen[d];
      if (src_cs[d]) chk("src_addr", 32'(src_addr[d]), wr_cnt[d]);
      if (done[d]) begin
        done_cnt[d]++;
        done_rel[d] = cyc - t0[d];
        chk("done_busy", 32'(busy[d]), 0);
      end
      if (src_cs[d]) begin
        src_ok[d] = (wcnt[d] == lat[d][src_addr[d]]);
        wcnt[d]++;
      end else begin
        src_ok[d] = 1'($urandom);
        wcnt[d]   = 0;
      end
      src_data[d] = (src_ok[d] && src_cs[d]) ?
                    mem[d][src_addr[d]] : 8'($urandom);
    end
`ifndef JTCONTRA_PALDMA_VBLANK_EN
    LVBL = 1'($urandom);
`endif
  end

  task automatic chk_rst(input int d);
    chk("rst_busy", 32'(busy[d]), 0);
    chk("rst_done", 32'(done[d]), 0);
    chk("rst_src_cs", 32'(src_cs[d]), 0);
    chk("rst_src_addr", 32'(src_addr[d]), 0);
    chk("rst_pal_cs", 32'(pal_cs[d]), 0);
    chk("rst_rnw", 32'(cpu_rnw[d]), 1);
    chk("rst_cen", 32'(cpu_cen[d]), 0);
    chk("rst_pal_addr", 32'(pal_addr[d]), 0);
    chk("rst_pal_din", 32'(pal_din[d]), 0);
  endtask

  task automatic prep(input int d, input int lv, input int rnd);
    for (int i = 0; i < 256; i++) begin
      lat[d][i] = (lv < 0) ? int'($urandom_range(0, 3)) : lv;
      mem[d][i] = (rnd != 0) ? 8'($urandom) : ~8'(i);
    end
    wr_cnt[d]   = 0;
    done_cnt[d] = 0;
    done_rel[d] = -1;
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    t0[d]    = cyc;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    int n;
    int model;
    int to;
    n = (v.d == 0) ? LA : LB;
    prep(v.d, v.lat, v.rnd_data);
    // each byte: WAIT + FETCH + WRITE plus its source latency
    model = 1;
    for (int i = 0; i < n; i++) model += 3 + lat[v.d][i];
    pulse_start(v.d);
    to = 0;
    if (v.abort_at >= 0) begin
      while (!(src_cs[v.d] && int'(src_addr[v.d]) == v.abort_at) &&
             to < 4000) begin
        @(negedge clk);
        to++;
      end
      chk("abort_reached", 32'(to < 4000), 1);
      abort[v.d] = 1'b1;
      @(negedge clk);
      abort[v.d] = 1'b0;
      chk("abort_idle_busy", 32'(busy[v.d]), 0);
      chk("abort_idle_cs", 32'(src_cs[v.d]), 0);
      repeat (20) @(negedge clk);
    end else begin
      while (done_cnt[v.d] == 0 && to < 4000) begin
        @(negedge clk);
        to++;
      end
      repeat (3) @(negedge clk);
    end
    chk("writes", wr_cnt[v.d], v.exp_wr);
    chk("done_count", done_cnt[v.d], (v.exp_done == 0) ? 0 : 1);
    if (v.exp_done != 0)
      chk("done_cycle", done_rel[v.d],
          (v.exp_done < 0) ? model : v.exp_done);
  endtask

  vec_t tbl[8];

  initial begin
    int to;
    int w;
    vec_t v;
`ifdef JTCONTRA_PALDMA_VBLANK_EN
    LVBL = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      prep(d, 0, 0);
      wcnt[d] = 0;
      prev_cen[d] = 1'b0;
      t0[d] = 0;
    end
    tbl[0] = '{0, 0, -1, 0, 256, 769};
    tbl[1] = '{1, 0, -1, 1, 4, 13};
    tbl[2] = '{1, 3, -1, 1, 4, 25};
    tbl[3] = '{0, 0, 5, 1, 5, 0};
    tbl[4] = '{0, 1, -1, 1, 256, 1025};
    tbl[5] = '{1, 2, 2, 1, 2, 0};
    tbl[6] = '{1, -1, -1, 1, 4, -1};
    tbl[7] = '{0, -1, -1, 1, 256, -1};

    repeat (3) @(negedge clk);
    chk_rst(0);
    chk_rst(1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // abort and start together in IDLE: stays idle
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("abort_wins_busy", 32'(busy[1]), 0);
    repeat (4) @(negedge clk);
    chk("abort_wins_cs", 32'(src_cs[1]), 0);

    foreach (tbl[i]) xfer(tbl[i]);
    for (int r = 0; r < 4; r++) begin
      v = '{1, -1, -1, 1, 4, -1};
      xfer(v);
    end

    // start during busy is ignored, then reset lands on a WRITE
    prep(0, 0, 1);
    pulse_start(0);
    to = 0;
    while (wr_cnt[0] < 2 && to < 200) begin
      @(negedge clk);
      to++;
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    to = 0;
    while (!cpu_cen[0] && to < 50) begin
      @(negedge clk);
      to++;
    end
    chk("rst_write_seen", 32'(cpu_cen[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_rst(0);
    rst = 1'b0;
    w = wr_cnt[0];
    repeat (20) @(negedge clk);
    chk("rst_no_writes", wr_cnt[0], w);
    chk("rst_no_done", done_cnt[0], 0);

`ifdef JTCONTRA_PALDMA_VBLANK_EN
    prep(1, 2, 1);
    LVBL = 1'b1;
    pulse_start(1);
    w = 0;
    repeat (100) begin
      @(negedge clk);
      if (src_cs[1]) w++;
    end
    chk("vb_no_fetch", w, 0);
    chk("vb_busy", 32'(busy[1]), 1);
    LVBL = 1'b0;
    to = 0;
    while (!(src_cs[1] && src_addr[1] == 8'd1) && to < 100) begin
      @(negedge clk);
      to++;
    end
    LVBL = 1'b1;
    w = 0;
    repeat (30) begin
      @(negedge clk);
      if (src_cs[1]) w++;
    end
    chk("vb_byte_done", wr_cnt[1], 2);
    chk("vb_paused", w, 0);
    LVBL = 1'b0;
    to = 0;
    while (done_cnt[1] == 0 && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("vb_writes", wr_cnt[1], 4);
    chk("vb_done", done_cnt[1], 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

endmodule
